// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache line memory: line geometry and FSM states.
package dcache_pkg;

  localparam int unsigned LINE_W   = 256;
  localparam int unsigned OFFSET_W = 5;
  localparam int unsigned ADDR_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/dcache_line_array.sv
// DEPTH x LINE_W line storage with one synchronous write port and one
// synchronous read port. The storage itself is never reset; only the read
// data register is cleared so the line memory's data_o starts at zero.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [LINE_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [LINE_W-1:0] rdata_q;

  // Line write: storage keeps its contents across reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read data register: holds the last line read until the next read.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dcache_line_mem.sv
// Backing line memory for the data cache: accepts one line read or write,
// waits a fixed latency, performs the access and pulses ack_o for one cycle.
module dcache_line_mem #(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          enable_i,
  input  logic                          write_i,
  input  logic [ADDR_W-1:0]             addr_i,
  input  logic [dcache_pkg::LINE_W-1:0] data_i,
  output logic [dcache_pkg::LINE_W-1:0] data_o,
  output logic                          ack_o,
  output logic                          busy_o
);

  import dcache_pkg::*;

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

  mem_state_e        state_q;
  logic [7:0]        cnt_q;
  logic              wr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic              ack_q;
  logic              busy_q;
  logic              mem_we_s;
  logic              mem_re_s;
  logic              unused_s;

  // Offset bits and bits above the line index only alias lines.
  assign unused_s = ^{addr_i[OFFSET_W-1:0], addr_i[ADDR_W-1:OFFSET_W+IDX_W]};

  // Access strobes fire on the edge that ends the last WAIT cycle; a reset on
  // that same edge suppresses the commit.
  always_comb begin
    mem_we_s = 1'b0;
    mem_re_s = 1'b0;
    if (rst_n_i && (state_q == WAIT) && (cnt_q == 8'd0)) begin
      mem_we_s = wr_q;
      mem_re_s = ~wr_q;
    end else begin
      mem_we_s = 1'b0;
      mem_re_s = 1'b0;
    end
  end

  // Request FSM: capture in IDLE, count down in WAIT, one-cycle ack in RESP.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          if (enable_i) begin
            wr_q    <= write_i;
            idx_q   <= addr_i[OFFSET_W +: IDX_W];
            wdata_q <= data_i;
            cnt_q   <= CNT_INIT;
            state_q <= WAIT;
            busy_q  <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            ack_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 8'd0;
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  dcache_line_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we_i    (mem_we_s),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .re_i    (mem_re_s),
    .raddr_i (idx_q),
    .rdata_o (data_o)
  );

  assign ack_o  = ack_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_dcache_line_mem.sv
// Self-checking bench for dcache_line_mem: directed scenarios plus random
// line traffic checked against a simple line-indexed memory model.
module tb_dcache_line_mem;

  localparam int L = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         write;
  logic [31:0]  addr;
  logic [255:0] wdata;
  logic [255:0] rdata;
  logic         ack;
  logic         busy;

  int total = 0;
  int bad   = 0;

  logic [255:0] mem_m [int];
  logic [255:0] exp_data;
  int           lines_q [$];

  always #5 clk = ~clk;

  dcache_line_mem #(.LATENCY(L), .DEPTH(512), .ADDR_W(32)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .enable_i (enable),
    .write_i  (write),
    .addr_i   (addr),
    .data_i   (wdata),
    .data_o   (rdata),
    .ack_o    (ack),
    .busy_o   (busy)
  );

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32'd32) % 32'd512);
  endfunction

  function automatic logic [255:0] rnd_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [31:0] addr_for(input int ln);
    logic [31:0] r;
    r = $urandom;
    return (r & 32'hFFFF_C000) | (32'(ln) << 5) | (r & 32'h0000_001F);
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    write = 1'($urandom);
    addr  = $urandom;
    wdata = rnd_line();
  endtask

  // One request: presented now (just after a falling edge), accepted at the
  // next rising edge, then checked every cycle through ack and back to idle.
  task automatic txn(input bit wr, input logic [31:0] a, input logic [255:0] d,
                     input bit scr, input bit hold);
    int last;
    int ln;
    ln   = line_of(a);
    last = hold ? L + 1 : L + 2;
    enable = 1'b1;
    write  = wr;
    addr   = a;
    wdata  = d;
    @(posedge clk);
    #1;
    if (scr) scramble();
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == L) begin
        if (wr) mem_m[ln] = d;
        else    exp_data  = mem_m[ln];
      end
      chk("ack",    {255'd0, ack},  {255'd0, (c == L)});
      chk("busy",   {255'd0, busy}, {255'd0, (c <= L)});
      chk("data_o", rdata, exp_data);
      if (scr && c < L) scramble();
      if (c == L && !hold) enable = 1'b0;
    end
  endtask

  initial begin
    logic [255:0] dat;
    logic [255:0] beef;
    int           ln;
    bit           wr;
    bit           hold;

    beef     = {8{32'hDEADBEEF}};
    exp_data = 256'd0;

    // Reset held with enable asserted.
    rst_n  = 1'b0;
    enable = 1'b1;
    write  = 1'b1;
    addr   = 32'h0000_0040;
    wdata  = rnd_line();
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_ack",  {255'd0, ack},  256'd0);
      chk("rst_busy", {255'd0, busy}, 256'd0);
      chk("rst_data", rdata, 256'd0);
    end
    rst_n  = 1'b1;
    enable = 1'b0;
    @(negedge clk);

    // Write then read with offset bits set.
    txn(1'b1, 32'h0000_0040, beef, 1'b0, 1'b0);
    chk("wr_data_unchanged", rdata, 256'd0);
    txn(1'b0, 32'h0000_005F, rnd_line(), 1'b0, 1'b0);
    chk("rd_offset_ignored", rdata, beef);

    // Aliasing modulo DEPTH.
    dat = rnd_line();
    txn(1'b1, 32'h0000_4000, dat, 1'b0, 1'b0);
    txn(1'b0, 32'h0000_0000, rnd_line(), 1'b0, 1'b0);
    chk("alias", rdata, dat);

    // Inputs changing every cycle while waiting.
    dat = rnd_line();
    txn(1'b1, 32'h0000_0080, dat, 1'b1, 1'b0);
    txn(1'b0, 32'h0000_0080, rnd_line(), 1'b1, 1'b0);
    chk("scramble_raw", rdata, dat);

    // Back-to-back with enable held through the response.
    txn(1'b1, 32'h0000_01A0, rnd_line(), 1'b0, 1'b1);
    txn(1'b0, 32'h0000_01A0, rnd_line(), 1'b0, 1'b0);
    chk("b2b_raw", rdata, mem_m[13]);

    // Reset five cycles into a write to 0x80: aborted, old line kept.
    enable = 1'b1;
    write  = 1'b1;
    addr   = 32'h0000_0080;
    wdata  = rnd_line();
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("abort_ack",  {255'd0, ack},  256'd0);
      chk("abort_busy", {255'd0, busy}, 256'd1);
    end
    rst_n  = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    exp_data = 256'd0;
    chk("abort_rst_busy", {255'd0, busy}, 256'd0);
    chk("abort_rst_data", rdata, exp_data);
    rst_n = 1'b1;
    repeat (L + 3) begin
      @(posedge clk);
      @(negedge clk);
      chk("abort_no_ack", {255'd0, ack},  256'd0);
      chk("abort_idle",   {255'd0, busy}, 256'd0);
    end
    txn(1'b0, 32'h0000_0080, rnd_line(), 1'b0, 1'b0);
    chk("abort_old_data", rdata, dat);

    // Random traffic over a small set of lines with random upper bits.
    for (int n = 0; n < 30; n++) begin
      wr = (lines_q.size() == 0) || ($urandom_range(0, 1) == 1);
      if (wr) begin
        ln = ($urandom_range(0, 7) * 61) % 512;
        lines_q.push_back(ln);
      end else begin
        ln = lines_q[$urandom_range(0, lines_q.size() - 1)];
      end
      hold = (n != 29) && ($urandom_range(0, 3) == 0);
      txn(wr, addr_for(ln), rnd_line(), 1'($urandom), hold);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
